// File: rtl/gsu_mem_responder.sv
// Responder end of the GSU gamepak bus: decodes byte requests onto the ROM or
// RAM pins, runs setup / wait-state access strobes and returns a one-cycle response.
module gsu_mem_responder #(
    parameter int ROM_WAIT = 3,
    parameter int RAM_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic        req_we,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic [20:0] rom_addr,
    output logic        rom_oe_n,
    input  logic [7:0]  rom_rdata,
    output logic [16:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_ce_n,
    output logic        ram_oe_n,
    output logic        ram_we_n,
    input  logic [7:0]  ram_rdata
);
    localparam int MAX_WAIT = (ROM_WAIT > RAM_WAIT) ? ROM_WAIT : RAM_WAIT;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] ROM_LOAD = CNT_W'(ROM_WAIT);
    localparam logic [CNT_W-1:0] RAM_LOAD = CNT_W'(RAM_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        REG_ROM_LO = 2'd0,
        REG_ROM_HI = 2'd1,
        REG_RAM    = 2'd2,
        REG_NONE   = 2'd3
    } region_t;

    function automatic region_t decode_region(input logic [7:0] bank);
        region_t r;
        if (bank[7]) begin
            r = REG_NONE;
        end else if (!bank[6]) begin
            r = REG_ROM_LO;
        end else if (!bank[5]) begin
            r = REG_ROM_HI;
        end else begin
            r = REG_RAM;
        end
        return r;
    endfunction

    // Low ROM banks only expose the upper 32 kB half of each bank, so bit 15 drops out.
    function automatic logic [20:0] rom_phys(input logic [23:0] addr, input region_t r);
        logic [20:0] p;
        if (r == REG_ROM_LO) begin
            p = {addr[21:16], addr[14:0]};
        end else begin
            p = addr[20:0];
        end
        return p;
    endfunction

    state_t           state_r, state_nxt_s;
    region_t          req_region_s;
    logic             hs_s, req_ram_s, req_err_s;
    logic             tgt_ram_s, tgt_we_s, tgt_err_s;
    logic             we_r, err_r, ram_r;
    logic [CNT_W-1:0] cnt_r;
    logic             req_ready_r, rsp_valid_r, rsp_err_r;
    logic [7:0]       rsp_rdata_r, rsp_rdata_nxt_s;
    logic [20:0]      rom_addr_r;
    logic [16:0]      ram_addr_r;
    logic [7:0]       ram_wdata_r;
    logic             rom_oe_n_r, ram_ce_n_r, ram_oe_n_r, ram_we_n_r;
    logic             rom_oe_n_nxt_s, ram_ce_n_nxt_s, ram_oe_n_nxt_s, ram_we_n_nxt_s;

    // Request decode; while idle the live request is the target, afterwards the latched one.
    always_comb begin
        req_region_s = decode_region(req_addr[23:16]);
        hs_s         = req_valid & req_ready_r;
        req_ram_s    = (req_region_s == REG_RAM);
        req_err_s    = (req_region_s == REG_NONE) | (~req_ram_s & req_we);
        if (state_r == ST_IDLE) begin
            tgt_ram_s = req_ram_s;
            tgt_we_s  = req_we;
            tgt_err_s = req_err_s;
        end else begin
            tgt_ram_s = ram_r;
            tgt_we_s  = we_r;
            tgt_err_s = err_r;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (hs_s) begin
                    if (req_err_s) begin
                        state_nxt_s = ST_RESP;
                    end else begin
                        state_nxt_s = ST_SETUP;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: state_nxt_s = ST_ACCESS;
            ST_ACCESS: begin
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Strobes and response data are computed for the state being entered, then registered.
    always_comb begin
        rom_oe_n_nxt_s  = 1'b1;
        ram_ce_n_nxt_s  = 1'b1;
        ram_oe_n_nxt_s  = 1'b1;
        ram_we_n_nxt_s  = 1'b1;
        rsp_rdata_nxt_s = rsp_rdata_r;
        case (state_nxt_s)
            ST_SETUP: begin
                rom_oe_n_nxt_s = tgt_ram_s;
                ram_ce_n_nxt_s = ~tgt_ram_s;
                ram_oe_n_nxt_s = ~(tgt_ram_s & ~tgt_we_s);
            end
            ST_ACCESS: begin
                rom_oe_n_nxt_s = tgt_ram_s;
                ram_ce_n_nxt_s = ~tgt_ram_s;
                ram_oe_n_nxt_s = ~(tgt_ram_s & ~tgt_we_s);
                ram_we_n_nxt_s = ~(tgt_ram_s & tgt_we_s);
            end
            ST_RESP: begin
                if (tgt_we_s) begin
                    rsp_rdata_nxt_s = 8'h00;
                end else if (tgt_err_s) begin
                    rsp_rdata_nxt_s = 8'hFF;
                end else if (tgt_ram_s) begin
                    rsp_rdata_nxt_s = ram_rdata;
                end else begin
                    rsp_rdata_nxt_s = rom_rdata;
                end
            end
            default: begin
                rom_oe_n_nxt_s = 1'b1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Wait counter: loaded in SETUP, counts down to one during ACCESS.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else begin
            case (state_r)
                ST_SETUP: cnt_r <= ram_r ? RAM_LOAD : ROM_LOAD;
                ST_ACCESS: begin
                    if (cnt_r != CNT_ONE) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Request attributes latched on the handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_r  <= 1'b0;
            err_r <= 1'b0;
            ram_r <= 1'b0;
        end else if (hs_s) begin
            we_r  <= req_we;
            err_r <= req_err_s;
            ram_r <= req_ram_s;
        end else begin
            we_r  <= we_r;
        end
    end

    // Physical address/data registers; held through RESP for write hold time.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rom_addr_r  <= 21'h000000;
            ram_addr_r  <= 17'h00000;
            ram_wdata_r <= 8'h00;
        end else if (hs_s && !req_err_s) begin
            if (req_ram_s) begin
                ram_addr_r  <= req_addr[16:0];
                ram_wdata_r <= req_wdata;
            end else begin
                rom_addr_r  <= rom_phys(req_addr, req_region_s);
            end
        end else begin
            rom_addr_r <= rom_addr_r;
        end
    end

    // Registered handshake, response and strobe outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 8'h00;
            rom_oe_n_r  <= 1'b1;
            ram_ce_n_r  <= 1'b1;
            ram_oe_n_r  <= 1'b1;
            ram_we_n_r  <= 1'b1;
        end else begin
            req_ready_r <= (state_nxt_s == ST_IDLE);
            rsp_valid_r <= (state_nxt_s == ST_RESP);
            rsp_err_r   <= (state_nxt_s == ST_RESP) & tgt_err_s;
            rsp_rdata_r <= rsp_rdata_nxt_s;
            rom_oe_n_r  <= rom_oe_n_nxt_s;
            ram_ce_n_r  <= ram_ce_n_nxt_s;
            ram_oe_n_r  <= ram_oe_n_nxt_s;
            ram_we_n_r  <= ram_we_n_nxt_s;
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rom_addr  = rom_addr_r;
    assign rom_oe_n  = rom_oe_n_r;
    assign ram_addr  = ram_addr_r;
    assign ram_wdata = ram_wdata_r;
    assign ram_ce_n  = ram_ce_n_r;
    assign ram_oe_n  = ram_oe_n_r;
    assign ram_we_n  = ram_we_n_r;

endmodule

// File: doc/gsu_mem_responder.md
# gsu_mem_responder

Responder end of the GSU gamepak bus. It accepts byte-wide read/write requests carrying a 24-bit bus address and decodes them into ROM (up to 2 MB) or gamepak RAM (up to 128 kB) physical addresses. It runs the multi-cycle strobe sequence on the selected physical memory and returns a single-cycle response. It sits between the bus-side request initiator and the external ROM/RAM pins.

## Interface
Parameters:
- ROM_WAIT, 3, ROM access cycles with `rom_oe_n` low after setup (>=1)
- RAM_WAIT, 2, RAM access cycles with `ram_oe_n`/`ram_we_n` low after setup (>=1)

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  responder idle, accepts this cycle
- req_addr  input  24  bus address {bank, offset}
- req_we  input  1  1 = write, 0 = read
- req_wdata  input  8  write data
- rsp_valid  output  1  one-cycle response pulse
- rsp_rdata  output  8  read data, valid with rsp_valid
- rsp_err  output  1  unmapped access or ROM write, valid with rsp_valid
- rom_addr  output  21  ROM physical address
- rom_oe_n  output  1  ROM output enable
- rom_rdata  input  8  ROM data
- ram_addr  output  17  RAM physical address
- ram_wdata  output  8  RAM write data
- ram_ce_n, ram_oe_n, ram_we_n  output  1 each  RAM strobes
- ram_rdata  input  8  RAM data

## Operation
- Decode applies to the latched address:
  - Banks 0x00–0x3f map to ROM. `rom_addr = {addr[21:16], addr[14:0]}`, so offsets 0000–7fff and 8000–ffff alias.
  - Banks 0x40–0x5f map to ROM. `rom_addr = addr[20:0]`.
  - Banks 0x60–0x7f map to RAM. `ram_addr = addr[16:0]`, so every pair of banks aliases.
  - Banks 0x80–0xff are unmapped.
- FSM states are IDLE, SETUP, ACCESS, RESP. Handshake fires when `req_valid & req_ready`. `req_ready` is 1 exactly in IDLE.
- IDLE, on handshake:
  - Latch addr, we and wdata.
  - Mapped ROM read or any RAM access goes to SETUP.
  - Unmapped access or ROM write goes to RESP with the error flag set. No strobes are asserted.
- SETUP lasts 1 cycle.
  - The physical address (and `ram_wdata`) is driven from that cycle through RESP.
  - ROM: `rom_oe_n` = 0.
  - RAM: `ram_ce_n` = 0. `ram_oe_n` = 0 for a read. `ram_we_n` stays 1.
  - Load the wait counter with ROM_WAIT or RAM_WAIT, then go to ACCESS.
- ACCESS lasts exactly WAIT cycles.
  - Strobes are held as in SETUP, except that for a RAM write `ram_we_n` = 0.
  - On the last cycle, reads capture `rom_rdata`/`ram_rdata` into `rsp_rdata`, and the FSM goes to RESP.
- RESP lasts 1 cycle.
  - All strobes are 1. Address and wdata are held (write hold time).
  - `rsp_valid` = 1. `rsp_err` = the error flag.
  - `rsp_rdata`:
    - captured data for a read
    - 0xFF for an error read
    - 0x00 for any write
  - Next state is IDLE.
- No backpressure on the response: the initiator must take `rsp_valid` when pulsed.
- ROM and RAM strobes are never low in the same cycle.

## Timing
- Reset (`rst_n` = 0 at an edge):
  - state = IDLE, `req_ready` = 1 (registered, first visible after the reset edge)
  - `rsp_valid` = 0, `rsp_err` = 0, `rsp_rdata` = 0
  - `rom_addr` = 0, `ram_addr` = 0, `ram_wdata` = 0
  - all `*_n` strobes = 1
- Reset mid-operation: the pending request is dropped with no response. Strobes deassert on that same edge.
- Latency, counting the handshake edge as edge 0:
  - Mapped access: `rsp_valid` is high in cycle WAIT+2. `req_ready` returns in cycle WAIT+3.
  - Error access: `rsp_valid` is in cycle 1. `req_ready` returns in cycle 2.
- Maximum throughput is one mapped access per WAIT+3 cycles.
- The wait counter is `$clog2(max(ROM_WAIT,RAM_WAIT)+1)` bits and counts down to 1. It never wraps.
- Input `req_*` values are ignored outside the handshake cycle.
- `req_valid` held high while busy is not accepted until IDLE.

## Test plan
- ROM read at 0x01_8123, `rom_rdata` = 0x5A:
  - `rom_addr` = 0x008123
  - `rom_oe_n` low for 4 cycles (cycles 1–4)
  - `rsp_valid` in cycle 5 with `rsp_rdata` = 0x5A, `rsp_err` = 0
- ROM read at 0x45_ABCD: `rom_addr` = 0x05ABCD. Read at 0x01_0123 also gives `rom_addr` = 0x008123 (alias check).
- RAM write 0x63_1234 with data 0xC3, then read 0x61_1234:
  - `ram_addr` = 0x11234 for both accesses
  - `ram_we_n` low exactly in cycles 2–3
  - read returns 0xC3 with `rsp_valid` in cycle 4
- Error cases:
  - Write to 0x20_0000: no strobe toggles, `rsp_valid` = 1 and `rsp_err` = 1 in cycle 1.
  - Read 0x80_0000: `rsp_err` = 1, `rsp_rdata` = 0xFF.
- Back-to-back requests with `req_valid` held high: the second request is accepted exactly WAIT+3 cycles after the first. Exactly one `rsp_valid` per request.
- `rst_n` low during ACCESS of a RAM write:
  - all strobes = 1 after that edge, no `rsp_valid` produced
  - `req_ready` = 1 and a new request completes normally afterwards
